// File: rtl/instram_pkg.sv
// Shared definitions for the dual-port instruction RAM: clear-engine state
// encoding and the legal range of the write-data lag.
package instram_pkg;

    // Clear/fill engine states. The numeric values are visible on dbg_state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

    // Write data may trail its address/enable by this many cycles.
    localparam int LAG_MIN = 0;
    localparam int LAG_MAX = 3;

    // True when a requested data lag can be built by the write pipeline.
    function automatic bit lag_legal(input int lag);
        return (lag >= LAG_MIN) && (lag <= LAG_MAX);
    endfunction

endpackage

// File: rtl/wr_lag_pipe.sv
// Delay line for write requests: carries {valid, address} DEPTH cycles so the
// commit lines up with late-arriving write data. DEPTH = 0 is a wire.
module wr_lag_pipe #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_adr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_adr
);

    if (DEPTH == 0) begin : g_pass
        // No lag: the request commits in the cycle it is presented.
        logic w_unused;
        assign w_unused = i_clk ^ i_rst;
        assign o_valid  = i_valid;
        assign o_adr    = i_adr;
    end else begin : g_shift
        logic [DEPTH-1:0]  r_valid;
        logic [ADDR_W-1:0] r_adr [DEPTH];

        // Valid bits are cleared by reset so pending writes are discarded.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_valid <= '0;
            end else begin
                r_valid[0] <= i_valid;
                for (int i = 1; i < DEPTH; i++) begin
                    r_valid[i] <= r_valid[i-1];
                end
            end
        end

        // Addresses only matter while their valid bit is set, so no reset.
        always_ff @(posedge i_clk) begin
            r_adr[0] <= i_adr;
            for (int i = 1; i < DEPTH; i++) begin
                r_adr[i] <= r_adr[i-1];
            end
        end

        assign o_valid = r_valid[DEPTH-1];
        assign o_adr   = r_adr[DEPTH-1];
    end

endmodule

// File: rtl/instram_dp.sv
// Program store between the 6502 bus/loader and the CPU fetch path.
// One registered read port, one write port whose data trails its address by
// DATA_LAG cycles, optional write-to-read bypass, and a sweep engine that
// fills the whole array with FILL_VAL after reset or on request.
//
// Handshake: there is none. wr_en is a fire-and-forget request accepted every
// cycle (no backpressure); its wr_data must be on the bus exactly DATA_LAG
// cycles later. rd_en is a strobe: rd_data is valid the cycle after and holds
// until the next strobe. clr_req is a single-cycle pulse, ignored while busy.
module instram_dp
    import instram_pkg::*;
#(
    parameter int                ADDR_W         = 16,
    parameter int                DATA_W         = 8,
    parameter int                DATA_LAG       = 1,
    parameter int                BYPASS         = 1,
    parameter logic [DATA_W-1:0] FILL_VAL       = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_adr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] wr_adr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic [1:0]        dbg_state
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (!lag_legal(DATA_LAG)) begin : g_lag_check
        $error("instram_dp: DATA_LAG=%0d outside %0d..%0d", DATA_LAG, LAG_MIN, LAG_MAX);
    end

    clr_state_e        r_state;
    clr_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_pipe_valid;
    logic [ADDR_W-1:0] w_pipe_adr;
    logic              w_busy;
    logic              w_commit;
    logic              w_last;
    logic              w_hit;

    wr_lag_pipe #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DATA_LAG)
    ) u_wr_lag_pipe (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (wr_en),
        .i_adr   (wr_adr),
        .o_valid (w_pipe_valid),
        .o_adr   (w_pipe_adr)
    );

    // The engine owns the array only outside reset; reset parks the state in
    // CLEAR (when clearing on reset) so the sweep starts on the very first
    // cycle after rst drops, with busy still low while rst is held.
    assign w_busy   = (r_state == ST_CLEAR) && !rst;
    // User writes lose to the sweep; their pipeline slot simply expires.
    assign w_commit = w_pipe_valid && !w_busy && !rst;
    assign w_last   = &r_cnt;
    assign w_hit    = w_commit && (w_pipe_adr == rd_adr);

    // Clear-engine state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear-engine next state: one sweep of DEPTH cycles, then a done cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = clr_req ? ST_CLEAR : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sweep address; wraps back to 0 after DEPTH-1 ready for the next sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + ADDR_W'(1);
        end
    end

    // Single write port into the array, shared by the sweep and user commits.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_cnt] <= FILL_VAL;
        end else if (w_commit) begin
            r_mem[w_pipe_adr] <= wr_data;
        end
    end

    // Registered read; during a sweep the whole array is logically FILL_VAL.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (w_busy) begin
                rd_data <= FILL_VAL;
            end else if ((BYPASS != 0) && w_hit) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= r_mem[rd_adr];
            end
        end
    end

    assign busy      = w_busy;
    assign clr_done  = (r_state == ST_DONE) && !rst;
    assign dbg_state = r_state;

endmodule
